// File: rtl/i2c_temp_pkg.sv
// Shared types and constants for the LM75-style I2C temperature target.
// Pointer map, CONFIG bit positions and the FSM state encoding.
package i2c_temp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [1:0] PTR_TEMP   = 2'd0;
  localparam logic [1:0] PTR_CONFIG = 2'd1;
  localparam logic [1:0] PTR_THYST  = 2'd2;
  localparam logic [1:0] PTR_TOS    = 2'd3;

  localparam int CFG_SHDN = 0;
  localparam int CFG_POL  = 2;

  // Threshold registers only keep 0.5 C resolution.
  function automatic logic [15:0] thr_mask(input logic [15:0] v);
    return {v[15:7], 7'b0};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA synchronizer, glitch filter and bus-condition detection.
// A level change is accepted after FILT_LEN equal synchronized samples.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int CW = $clog2(FILT_LEN + 1);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] s1, s2, filt, prev;
  logic [1:0][CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      prev <= '1;
      cnt  <= '0;
    end else begin
      s1   <= {sda_raw, scl_raw};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl       = filt[0];
  assign sda       = filt[1];
  assign scl_rise  = filt[0] & ~prev[0];
  assign scl_fall  = ~filt[0] & prev[0];
  assign start_det = filt[0] & prev[0] & prev[1] & ~filt[1];
  assign stop_det  = filt[0] & prev[0] & ~prev[1] & filt[1];

endmodule

// File: rtl/i2c_temp_target.sv
// LM75-style I2C temperature sensor target with comparator ALERT.
// Drives an open-drain SDA enable; registers TEMP, CONFIG, THYST, TOS.
module i2c_temp_target
  import i2c_temp_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR  = 7'h48,
  parameter int          FILT_LEN  = 3,
  parameter logic [15:0] TOS_RST   = 16'h5000,
  parameter logic [15:0] THYST_RST = 16'h4B00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  input  logic [8:0] TEMP_IN,
  input  logic       TEMP_VALID,
  output logic       ALERT,
  output logic       BUSY
);

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk      (CLK),
    .rst      (RESET),
    .scl_raw  (SCL_IN),
    .sda_raw  (SDA_IN),
    .scl      (scl_f),
    .sda      (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t      state, state_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [6:0]  rx, rx_d;
  logic [6:0]  tx, tx_d;
  logic        sda_oe, sda_oe_d;
  logic        busy, busy_d;
  logic        rw, rw_d;
  logic        nack, nack_d;
  logic [1:0]  ptr, ptr_d;
  logic [1:0]  byte_idx, byte_idx_d;
  logic [7:0]  wr_hold, wr_hold_d;
  logic [7:0]  lsb_hold, lsb_hold_d;
  logic [7:0]  cfg, cfg_d;
  logic [15:0] tos, tos_d;
  logic [15:0] thyst, thyst_d;
  logic [15:0] temp;
  logic [15:0] reg_val;
  logic [7:0]  byte_in, tx_byte;
  logic        ld_rd, alert_flag;

  // SDA may only change while SCL is low.
  logic drive_ok;
  assign drive_ok = scl_fall & ~scl_f;
  assign byte_in  = {rx, sda_f};

  always_comb begin
    case (ptr)
      PTR_TEMP:   reg_val = temp;
      PTR_CONFIG: reg_val = {cfg, 8'h00};
      PTR_THYST:  reg_val = thyst;
      default:    reg_val = tos;
    endcase
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rx_d       = rx;
    tx_d       = tx;
    sda_oe_d   = sda_oe;
    busy_d     = busy;
    rw_d       = rw;
    nack_d     = nack;
    ptr_d      = ptr;
    byte_idx_d = byte_idx;
    wr_hold_d  = wr_hold;
    lsb_hold_d = lsb_hold;
    cfg_d      = cfg;
    tos_d      = tos;
    thyst_d    = thyst;
    ld_rd      = 1'b0;
    tx_byte    = '0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_in[7:1] == I2C_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // bit_cnt 0: ACK not yet driven; 1: ACK slot in progress.
        ADDR_ACK, PTR_ACK, WR_ACK: if (drive_ok) begin
          if (bit_cnt == 4'd0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state == ADDR_ACK && rw) begin
              state_d    = RD_DATA;
              byte_idx_d = '0;
              ld_rd      = 1'b1;
            end else if (state == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        PTR: if (scl_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_d  = '0;
            ptr_d      = byte_in[1:0];
            byte_idx_d = '0;
            state_d    = PTR_ACK;
          end
        end
        WR_DATA: if (scl_rise) begin
          rx_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = WR_ACK;
            if (byte_idx != 2'd2) byte_idx_d = byte_idx + 2'd1;
            case (ptr)
              PTR_CONFIG: if (byte_idx == 2'd0) cfg_d = byte_in;
              PTR_THYST: begin
                if (byte_idx == 2'd0) wr_hold_d = byte_in;
                if (byte_idx == 2'd1) thyst_d = thr_mask({wr_hold, byte_in});
              end
              PTR_TOS: begin
                if (byte_idx == 2'd0) wr_hold_d = byte_in;
                if (byte_idx == 2'd1) tos_d = thr_mask({wr_hold, byte_in});
              end
              default: ;
            endcase
          end
        end
        RD_DATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt + 4'd1;
          if (drive_ok) begin
            if (bit_cnt == 4'd8) begin
              state_d   = RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d = ~tx[6];
              tx_d     = {tx[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_d    = sda_f;
            bit_cnt_d = 4'd1;
          end else if (drive_ok && bit_cnt == 4'd1) begin
            bit_cnt_d = '0;
            if (nack) begin
              state_d = WAIT_STOP;
            end else begin
              state_d    = RD_DATA;
              byte_idx_d = {1'b0, ~byte_idx[0]};
              ld_rd      = 1'b1;
            end
          end
        end
        default: ;
      endcase
      // The MSB load snapshots the LSB so both bytes are coherent.
      if (ld_rd) begin
        if (!byte_idx_d[0]) begin
          tx_byte    = reg_val[15:8];
          lsb_hold_d = reg_val[7:0];
        end else begin
          tx_byte = lsb_hold;
        end
        tx_d     = tx_byte[6:0];
        sda_oe_d = ~tx_byte[7];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      ptr      <= PTR_TEMP;
      byte_idx <= '0;
      wr_hold  <= '0;
      lsb_hold <= '0;
      cfg      <= '0;
      tos      <= TOS_RST;
      thyst    <= THYST_RST;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      rx       <= rx_d;
      tx       <= tx_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      rw       <= rw_d;
      nack     <= nack_d;
      ptr      <= ptr_d;
      byte_idx <= byte_idx_d;
      wr_hold  <= wr_hold_d;
      lsb_hold <= lsb_hold_d;
      cfg      <= cfg_d;
      tos      <= tos_d;
      thyst    <= thyst_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      temp       <= '0;
      alert_flag <= 1'b0;
    end else begin
      if (TEMP_VALID && !cfg[CFG_SHDN]) temp <= {TEMP_IN, 7'b0};
      if ($signed(temp[15:7]) >= $signed(tos[15:7])) begin
        alert_flag <= 1'b1;
      end else if ($signed(temp[15:7]) < $signed(thyst[15:7])) begin
        alert_flag <= 1'b0;
      end
    end
  end

  assign SDA_OE = sda_oe;
  assign BUSY   = busy;
  assign ALERT  = ~(alert_flag ^ cfg[CFG_POL]);

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master with a byte scoreboard.
// Register write/readback table plus hand-written corner sequences.
module tb_i2c_temp_target;
  import i2c_temp_pkg::*;

  localparam int Q = 10;
  localparam logic [6:0] DEV = 7'h48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic temp_valid = 1'b0;
  logic [8:0] temp_in = '0;
  logic sda_oe, alert, busy;
  logic sda_bus;
  logic mon_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int hits = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]  ptr;
    logic [23:0] wdata;
    int          nbytes;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_temp_target dut (
    .CLK       (clk),
    .RESET     (rst),
    .SCL_IN    (scl),
    .SDA_IN    (sda_bus),
    .SDA_OE    (sda_oe),
    .TEMP_IN   (temp_in),
    .TEMP_VALID(temp_valid),
    .ALERT     (alert),
    .BUSY      (busy)
  );

  always @(negedge clk)
    if (mon_en && (sda_oe || busy)) hits <= hits + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string nm, input logic [7:0] b);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=%h want=<empty queue>", nm, b);
    end else begin
      check(nm, {8'h00, b}, {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    sda_m = 1'b0;
    tick(2 * Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    sda_m = 1'b1;
    tick(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gl,
                            output logic nk, output logic oe);
    for (int i = 7; i >= 0; i--) begin
      write_bit(d[i]);
      if (i == gl) begin
        scl = 1'b1;
        tick(2);
        scl = 1'b0;
      end
    end
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    nk = sda_bus;
    oe = sda_oe;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nk);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      b = {b[6:0], sda_bus};
      tick(Q);
      scl = 1'b0;
      tick(Q);
    end
    write_bit(nk);
  endtask

  task automatic write_reg(input logic [1:0] p, input logic [23:0] d,
                           input int n, input string nm);
    logic nk, oe;
    i2c_start();
    write_byte({DEV, 1'b0}, -1, nk, oe);
    check({nm, " w_addr_ack"}, {15'd0, oe}, 16'd1);
    write_byte({6'd0, p}, -1, nk, oe);
    check({nm, " w_ptr_ack"}, {15'd0, oe}, 16'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(d[23 - 8 * i -: 8], -1, nk, oe);
      check({nm, " w_data_ack"}, {15'd0, oe}, 16'd1);
    end
    i2c_stop();
  endtask

  task automatic read_reg(input logic [1:0] p, input logic [15:0] exp,
                          input string nm);
    logic nk, oe;
    logic [7:0] b;
    exp_q.push_back(exp[15:8]);
    exp_q.push_back(exp[7:0]);
    i2c_start();
    write_byte({DEV, 1'b0}, -1, nk, oe);
    check({nm, " r_addr_ack"}, {15'd0, oe}, 16'd1);
    check({nm, " busy"}, {15'd0, busy}, 16'd1);
    write_byte({6'd0, p}, -1, nk, oe);
    check({nm, " r_ptr_ack"}, {15'd0, oe}, 16'd1);
    i2c_start();
    write_byte({DEV, 1'b1}, -1, nk, oe);
    check({nm, " rd_addr_ack"}, {15'd0, oe}, 16'd1);
    read_byte(b, 1'b0);
    pop_check({nm, " msb"}, b);
    read_byte(b, 1'b1);
    pop_check({nm, " lsb"}, b);
    i2c_stop();
  endtask

  task automatic strobe(input logic [8:0] v);
    @(negedge clk);
    temp_in = v;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  initial begin
    logic nk, oe;
    logic [7:0] b;
    int h0;

    tbl[0] = '{PTR_TOS,    24'h1E7F00, 2, 16'h1E00};
    tbl[1] = '{PTR_THYST,  24'h14AA00, 2, 16'h1480};
    tbl[2] = '{PTR_CONFIG, 24'hFA0000, 1, 16'hFA00};
    tbl[3] = '{PTR_CONFIG, 24'h000000, 1, 16'h0000};
    tbl[4] = '{PTR_TEMP,   24'hABCD00, 2, 16'h1900};
    tbl[5] = '{PTR_TOS,    24'h2300FF, 3, 16'h2300};

    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset sda_oe", {15'd0, sda_oe}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset alert", {15'd0, alert}, 16'd1);
    tick(20);

    strobe(9'h032);
    read_reg(PTR_TEMP, 16'h1900, "temp");
    tick(4);
    check("busy after stop", {15'd0, busy}, 16'd0);

    mon_en = 1'b1;
    h0 = hits;
    i2c_start();
    write_byte({7'h49, 1'b0}, -1, nk, oe);
    check("wrong addr nack", {15'd0, nk}, 16'd1);
    write_byte(8'h00, -1, nk, oe);
    i2c_stop();
    tick(2);
    mon_en = 1'b0;
    check("wrong addr quiet", 16'(hits - h0), 16'd0);

    for (int i = 0; i < 6; i++) begin
      write_reg(tbl[i].ptr, tbl[i].wdata, tbl[i].nbytes, $sformatf("tbl%0d", i));
      read_reg(tbl[i].ptr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    write_reg(PTR_TOS, 24'h1E0000, 2, "al_tos");
    write_reg(PTR_THYST, 24'h140000, 2, "al_thyst");
    write_reg(PTR_CONFIG, 24'h000000, 1, "al_cfg");
    check("alert idle", {15'd0, alert}, 16'd1);
    strobe(9'h03C);
    check("alert lag", {15'd0, alert}, 16'd1);
    tick(1);
    check("alert set 03c", {15'd0, alert}, 16'd0);
    strobe(9'h032);
    tick(2);
    check("alert hold 032", {15'd0, alert}, 16'd0);
    strobe(9'h027);
    tick(2);
    check("alert clear 027", {15'd0, alert}, 16'd1);

    exp_q.push_back(8'h13);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h00);
    i2c_start();
    write_byte({DEV, 1'b0}, -1, nk, oe);
    check("coh addr ack", {15'd0, oe}, 16'd1);
    write_byte(8'h00, -1, nk, oe);
    check("coh ptr ack", {15'd0, oe}, 16'd1);
    i2c_start();
    write_byte({DEV, 1'b1}, -1, nk, oe);
    check("coh rd ack", {15'd0, oe}, 16'd1);
    read_byte(b, 1'b0);
    pop_check("coh msb0", b);
    strobe(9'h0AA);
    read_byte(b, 1'b0);
    pop_check("coh lsb0", b);
    read_byte(b, 1'b0);
    pop_check("coh msb1", b);
    read_byte(b, 1'b1);
    pop_check("coh lsb1", b);
    i2c_stop();

    write_reg(PTR_CONFIG, 24'h010000, 1, "shdn_on");
    strobe(9'h1F6);
    tick(2);
    check("shdn alert held", {15'd0, alert}, 16'd0);
    read_reg(PTR_TEMP, 16'h5500, "shdn_temp");
    write_reg(PTR_CONFIG, 24'h000000, 1, "shdn_off");
    strobe(9'h1F6);
    tick(2);
    check("neg alert clear", {15'd0, alert}, 16'd1);
    read_reg(PTR_TEMP, 16'hFB00, "neg_temp");

    i2c_start();
    write_byte({DEV, 1'b0}, 5, nk, oe);
    check("glitch addr ack", {15'd0, oe}, 16'd1);
    check("glitch bus ack", {15'd0, nk}, 16'd0);
    write_byte(8'h03, -1, nk, oe);
    check("glitch ptr ack", {15'd0, oe}, 16'd1);
    i2c_stop();
    read_reg(PTR_TOS, 16'h1E00, "glitch_tos");

    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : DEV[i - 1]);
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    check("rst ack driven", {15'd0, sda_oe}, 16'd1);
    rst = 1'b1;
    #1;
    check("rst sda_oe", {15'd0, sda_oe}, 16'd0);
    check("rst busy", {15'd0, busy}, 16'd0);
    check("rst alert", {15'd0, alert}, 16'd1);
    tick(2);
    rst = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
    i2c_stop();
    read_reg(PTR_TOS, 16'h5000, "rst_tos");
    read_reg(PTR_THYST, 16'h4B00, "rst_thyst");
    read_reg(PTR_CONFIG, 16'h0000, "rst_cfg");
    read_reg(PTR_TEMP, 16'h0000, "rst_temp");

    check("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
